fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the byte FIFO; runs entirely in the FIFO read clock domain.
- Pops bytes through the FIFO read handshake (rinc/empty/rdata), honouring the FIFO's one-cycle registered read latency.
- Packs the bytes little-endian into BYTES_PER_WORD-byte words and presents them on a valid/ready output stream.
- A flush input forces out a partial word with a byte count.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 2..8.
- CW, 4, width of the byte counters; must hold the value BYTES_PER_WORD.

Ports:
- rclk  input  1  read-domain clock; all logic on posedge.
- rrst_n  input  1  reset, synchronous, active-low.
- en  input  1  pop enable; 0 = issue no new pops (in-flight captures still complete).
- empty  input  1  FIFO empty flag, registered in rclk domain.
- rdata  input  8  FIFO read data; valid the cycle after a pop.
- rinc  output  1  pop request to FIFO.
- flush  input  1  single-cycle request to emit the current partial word.
- m_data  output  8*BYTES_PER_WORD  packed word; byte k at bits [8k+7:8k].
- m_bytes  output  CW  number of valid bytes in m_data (1..BYTES_PER_WORD).
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.

Behaviour:
- Synchronous, active-low reset: one clock and one reset, rclk and rrst_n; rrst_n is sampled only on posedge rclk.
- Reset values (rrst_n=0 at posedge rclk): m_valid=0, m_data=0, m_bytes=0, issued_cnt=0, cap_cnt=0, pop_d=0, flush_pend=0, assembly buffer=0.
- rinc is combinational: rinc = en & !empty & (issued_cnt < BYTES_PER_WORD) & !flush_pend. rinc is never asserted while empty=1.
- A pop is counted only when rinc=1 at the clock edge; issued_cnt increments on that edge.
- pop_d registers rinc.
- Data capture: when pop_d=1, rdata is written into byte lane cap_cnt of the assembly buffer and cap_cnt increments. Lane 0 holds the first byte popped.
- At most one pop is in flight (latency 1); issued_cnt - cap_cnt is 0 or 1.
- Output register: updated only when it is free, i.e. (m_valid=0 | m_ready=1).
- Transfer, full word: when cap_cnt==BYTES_PER_WORD, pop_d=0 and the output register is free:
  - m_data <= buffer, m_bytes <= BYTES_PER_WORD, m_valid <= 1;
  - issued_cnt and cap_cnt clear to 0; buffer clears to 0.
- If the output register is not free, the assembly stalls: no pops (issued_cnt is at max) and the buffer holds.
- On acceptance (m_valid & m_ready) with no new transfer in the same cycle, m_valid <= 0; m_data and m_bytes hold their last value.
- Back-to-back throughput: a new word may load in the same cycle the previous word is accepted.
- Flush: flush=1 sets flush_pend, which blocks new pops. When flush_pend=1, pop_d=0 and the output register is free:
  - cap_cnt>0: emit a partial word. m_bytes=cap_cnt; unused upper lanes are 0. Counters clear.
  - cap_cnt==0: no output; flush_pend clears.
  - flush_pend clears on emission.
- Flush in the same cycle as a full-word transfer: the full word wins; flush_pend stays set and then resolves with cap_cnt==0, producing no extra word.
- Flush with no valid data produces no output.
- Empty asserted mid-word: pops pause and the partial word holds indefinitely until more data arrives or flush is applied.
- en=0 mid-word: the in-flight capture completes and no further pops occur. The output side keeps operating.
- m_valid/m_data/m_bytes stay stable while m_valid=1 & m_ready=0. m_valid deasserts only after acceptance or reset.
- Reset mid-operation (rrst_n=0): all state returns to reset values on that edge. A pending pop's data is dropped.
- rinc is low while rrst_n=0.
- Counters never exceed BYTES_PER_WORD; no wrap.

Test Plan:
- Reset held low 3 cycles with empty=0 -> rinc=0, m_valid=0, m_data=0, m_bytes=0 throughout. After release, rinc=1 on the first cycle.
- FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1, en=1 -> exactly 4 rinc pulses. m_data=0x44332211, m_bytes=4, m_valid high 1 cycle. No fifth pop until more data arrives.
- 8 bytes 0x01..0x08, m_ready=0 for 10 cycles then 1 -> first word 0x04030201 held stable; pops stop after byte 8. After m_ready rises, 0x04030201 then 0x08070605 on consecutive cycles.
- empty toggles every other cycle while popping 0xA0..0xA3 -> rinc only when empty=0. Output word is 0xA3A2A1A0.
- Pop 0x55,0x66, then empty=1, then flush pulse -> m_data=0x00006655, m_bytes=2. Flush again with nothing captured -> no m_valid.
- Pop 2 bytes, then rrst_n=0 one cycle, then 4 new bytes 0xB0..0xB3 -> single output word 0xB3B2B1B0, m_bytes=4. No stale bytes appear.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes with one-cycle read latency and packs them
// little-endian into words on a valid/ready stream, with flush for partial words.
module fifo_rd_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int CW             = 4
) (
  input  logic                        rclk,
  input  logic                        rrst_n,
  input  logic                        en,
  input  logic                        empty,
  input  logic [7:0]                  rdata,
  output logic                        rinc,
  input  logic                        flush,
  output logic [8*BYTES_PER_WORD-1:0] m_data,
  output logic [CW-1:0]               m_bytes,
  output logic                        m_valid,
  input  logic                        m_ready
);

  localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

  logic [CW-1:0]               r_issued_cnt;
  logic [CW-1:0]               r_cap_cnt;
  logic                        r_pop_d;
  logic                        r_flush_pend;
  logic [8*BYTES_PER_WORD-1:0] r_buf;
  logic [8*BYTES_PER_WORD-1:0] r_m_data;
  logic [CW-1:0]               r_m_bytes;
  logic                        r_m_valid;

  logic w_out_free;
  logic w_full_xfer;
  logic w_flush_go;
  logic w_emit;

  // Pops are issued combinationally so a word can be gathered in back-to-back cycles.
  assign rinc = rrst_n & en & ~empty & (r_issued_cnt < FULL) & ~r_flush_pend;

  assign w_out_free  = ~r_m_valid | m_ready;
  assign w_full_xfer = (r_cap_cnt == FULL) & ~r_pop_d & w_out_free;
  // A full word always takes priority; a pending flush then resolves with nothing captured.
  assign w_flush_go  = r_flush_pend & ~r_pop_d & w_out_free & ~w_full_xfer;
  assign w_emit      = w_full_xfer | (w_flush_go & (r_cap_cnt != '0));

  assign m_data  = r_m_data;
  assign m_bytes = r_m_bytes;
  assign m_valid = r_m_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_issued_cnt <= '0;
      r_cap_cnt    <= '0;
      r_pop_d      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_buf        <= '0;
      r_m_data     <= '0;
      r_m_bytes    <= '0;
      r_m_valid    <= 1'b0;
    end else begin
      r_pop_d <= rinc;

      if (flush)
        r_flush_pend <= 1'b1;
      else if (w_flush_go)
        r_flush_pend <= 1'b0;

      if (w_emit) begin
        r_issued_cnt <= '0;
        r_cap_cnt    <= '0;
        r_buf        <= '0;
      end else begin
        if (rinc)
          r_issued_cnt <= r_issued_cnt + CW'(1);
        if (r_pop_d) begin
          for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (r_cap_cnt == CW'(k))
              r_buf[8*k +: 8] <= rdata;
          end
          r_cap_cnt <= r_cap_cnt + CW'(1);
        end
      end

      if (w_emit) begin
        r_m_data  <= r_buf;
        r_m_bytes <= w_full_xfer ? FULL : r_cap_cnt;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule
